// File: rtl/debounce_ctrl_if.sv
// ============================================================================
// Module   : debounce_ctrl_if
// Purpose  : Valid/ready command stream from the debounce controller to the
//            counter datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface debounce_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/debounce_ctrl.sv
// ============================================================================
// Module   : debounce_ctrl
// Purpose  : Shared m_tick generator, press/auto-repeat event detection and
//            round-robin command arbiter for four debounced buttons.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_ctrl #(
  parameter int TICK_DIV    = 1000000,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [3:0] btn_db,
  input  wire logic       repeat_en,
  output logic            m_tick,
  output logic            overrun,
  debounce_ctrl_if.master cmd
);

  localparam logic [23:0] C_TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [7:0]  C_DLY       = 8'(REPEAT_DLY);
  // Reload so each later repeat lands exactly REPEAT_RATE ticks after the last.
  localparam logic [7:0]  C_RELOAD    = 8'(REPEAT_DLY - REPEAT_RATE + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  logic [23:0] r_tick_cnt;
  logic        r_m_tick;
  logic [3:0]  r_btn_prev;
  logic [3:0]  r_pend;
  logic [7:0]  r_hold [4];
  logic        r_overrun;

  state_t      r_state, w_state_nx;
  logic        r_valid, w_valid_nx;
  logic [1:0]  r_id, w_id_nx;
  logic [1:0]  r_last, w_last_nx;

  logic [3:0]  w_rise;
  logic [3:0]  w_rep;
  logic [3:0]  w_evt;
  logic [3:0]  w_clr;
  logic [1:0]  w_pick;
  logic        w_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_m_tick   <= 1'b0;
    end else begin
      r_m_tick   <= (r_tick_cnt == C_TICK_LAST);
      r_tick_cnt <= (r_tick_cnt == C_TICK_LAST) ? '0 : r_tick_cnt + 24'd1;
    end
  end

  always_comb begin
    w_rise = btn_db & ~r_btn_prev;
    w_rep  = '0;
    for (int i = 0; i < 4; i++) begin
      w_rep[i] = repeat_en & r_m_tick & btn_db[i] & ~w_rise[i] & (r_hold[i] == C_DLY);
    end
    w_evt = w_rise | w_rep;
    w_clr = (r_valid & cmd.cmd_ready) ? (4'b0001 << r_id) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_prev <= '0;
      r_pend     <= '0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_btn_prev <= btn_db;
      r_pend     <= w_evt | (r_pend & ~w_clr);
      r_overrun  <= r_overrun | (|(w_evt & r_pend & ~w_clr));
      for (int i = 0; i < 4; i++) begin
        if (!btn_db[i] || w_rise[i]) begin
          r_hold[i] <= '0;
        end else if (r_m_tick) begin
          if (w_rep[i]) begin
            r_hold[i] <= C_RELOAD;
          end else if (r_hold[i] != 8'hFF) begin
            r_hold[i] <= r_hold[i] + 8'd1;
          end
        end
      end
    end
  end

  // Round-robin: scan starting one past the last granted button.
  always_comb begin
    w_pick  = r_last + 2'd1;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && r_pend[2'(r_last + 2'(k))]) begin
        w_pick  = r_last + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_valid;
    w_id_nx    = r_id;
    w_last_nx  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_valid_nx = 1'b1;
          w_id_nx    = w_pick;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd.cmd_ready) begin
          w_valid_nx = 1'b0;
          w_last_nx  = r_id;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_valid_nx = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= 2'd0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nx;
      r_valid <= w_valid_nx;
      r_id    <= w_id_nx;
      r_last  <= w_last_nx;
    end
  end

  assign m_tick        = r_m_tick;
  assign overrun       = r_overrun;
  assign cmd.cmd_valid = r_valid;
  assign cmd.cmd_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_debounce_ctrl.sv
// ============================================================================
// Module   : tb_debounce_ctrl
// Purpose  : Directed plus randomized self-checking bench for debounce_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_debounce_ctrl;

  localparam int TD   = 4;
  localparam int DLY  = 3;
  localparam int RATE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_db = 4'b0000;
  logic       repeat_en = 1'b0;
  logic       m_tick;
  logic       overrun;

  debounce_ctrl_if bus();

  debounce_ctrl #(
    .TICK_DIV    (TD),
    .REPEAT_DLY  (DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_db    (btn_db),
    .repeat_en (repeat_en),
    .m_tick    (m_tick),
    .overrun   (overrun),
    .cmd       (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset, ticks held per button.
  int       m_cyc;
  bit [3:0] m_prev;
  bit [3:0] m_pend;
  int       m_held [4];
  bit       m_valid;
  int       m_id;
  int       m_last;
  bit       m_ovr;
  bit       m_tick_exp;

  logic [1:0] acc_q [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit       tick_now;
    bit       accept;
    bit       evt;
    bit       clr;
    bit [3:0] new_pend;
    if (reset) begin
      m_cyc   = 0;
      m_prev  = '0;
      m_pend  = '0;
      for (int i = 0; i < 4; i++) m_held[i] = 0;
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = 3;
      m_ovr   = 1'b0;
    end else begin
      tick_now = (m_cyc != 0) && (m_cyc % TD == 0);
      accept   = m_valid && (bus.cmd_ready === 1'b1);
      new_pend = '0;
      for (int i = 0; i < 4; i++) begin
        evt = 1'b0;
        if (btn_db[i] && !m_prev[i]) begin
          evt = 1'b1;
          m_held[i] = 0;
        end else if (btn_db[i]) begin
          if (tick_now) begin
            m_held[i]++;
            if (repeat_en && m_held[i] >= DLY + 1 && ((m_held[i] - DLY - 1) % RATE) == 0)
              evt = 1'b1;
          end
        end else begin
          m_held[i] = 0;
        end
        clr = accept && (m_id == i);
        if (evt && m_pend[i] && !clr) m_ovr = 1'b1;
        new_pend[i] = evt | (m_pend[i] & !clr);
      end
      if (m_valid) begin
        if (accept) begin
          m_valid = 1'b0;
          m_last  = m_id;
        end
      end else if (m_pend != 0) begin
        for (int k = 4; k >= 1; k--) begin
          if (m_pend[(m_last + k) % 4]) m_id = (m_last + k) % 4;
        end
        m_valid = 1'b1;
      end
      m_pend = new_pend;
      m_prev = btn_db;
      m_cyc++;
    end
    m_tick_exp = (m_cyc != 0) && (m_cyc % TD == 0);
  endtask

  // One clock: record any handshake, advance the model, compare all outputs.
  task automatic step();
    if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) acc_q.push_back(bus.cmd_id);
    @(posedge clk);
    model_update();
    #1;
    check("m_tick", {7'd0, m_tick}, {7'd0, m_tick_exp});
    check("cmd_valid", {7'd0, bus.cmd_valid}, {7'd0, m_valid});
    check("overrun", {7'd0, overrun}, {7'd0, m_ovr});
    if (m_valid) check("cmd_id", {6'd0, bus.cmd_id}, 8'(m_id));
  endtask

  task automatic check_order(input string name, input int idx, input int exp);
    logic [7:0] act;
    act = (acc_q.size() > idx) ? {6'd0, acc_q[idx]} : 8'hFF;
    check(name, act, 8'(exp));
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Quiet period: ticks on cycles 4, 8, ...
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 4 || c == 8 || c == 20) check("tick_lit_hi", {7'd0, m_tick}, 8'd1);
      if (c == 5 || c == 7) check("tick_lit_lo", {7'd0, m_tick}, 8'd0);
    end
    check("quiet_valid", {7'd0, bus.cmd_valid}, 8'd0);

    // Single press, held, no repeat.
    bus.cmd_ready = 1'b1;
    acc_q.delete();
    btn_db = 4'b0001;
    step();
    check("press_valid_k", {7'd0, bus.cmd_valid}, 8'd0);
    step();
    check("press_valid_k1", {7'd0, bus.cmd_valid}, 8'd1);
    check("press_id_k1", {6'd0, bus.cmd_id}, 8'd0);
    step();
    check("press_valid_k2", {7'd0, bus.cmd_valid}, 8'd0);
    repeat (30) step();
    check("press_count", 8'(acc_q.size()), 8'd1);
    btn_db = 4'b0000;
    step();

    // Simultaneous presses from reset priority.
    reset = 1'b1;
    step();
    reset = 1'b0;
    acc_q.delete();
    btn_db = 4'b1111;
    repeat (10) step();
    check("all4_count", 8'(acc_q.size()), 8'd4);
    for (int k = 0; k < 4; k++) check_order("all4_order", k, k);
    btn_db = 4'b0000;
    repeat (2) step();
    acc_q.delete();
    btn_db = 4'b0011;
    repeat (6) step();
    check("pair_count", 8'(acc_q.size()), 8'd2);
    check_order("pair_order", 0, 0);
    check_order("pair_order", 1, 1);
    btn_db = 4'b0000;
    repeat (3) step();

    // Stall with re-press of the pending button.
    bus.cmd_ready = 1'b0;
    btn_db = 4'b0010;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn_db = 4'b0000;
      if (i == 5) btn_db = 4'b0010;
      step();
      check("stall_valid", {7'd0, bus.cmd_valid}, 8'd1);
      check("stall_id", {6'd0, bus.cmd_id}, 8'd1);
    end
    check("stall_overrun", {7'd0, overrun}, 8'd1);
    acc_q.delete();
    bus.cmd_ready = 1'b1;
    repeat (6) step();
    check("stall_count", 8'(acc_q.size()), 8'd1);
    check("stall_overrun_kept", {7'd0, overrun}, 8'd1);
    btn_db = 4'b0000;
    step();

    // Auto-repeat on button 2.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat_en = 1'b1;
    acc_q.delete();
    btn_db = 4'b0100;
    repeat (37) step();
    btn_db = 4'b0000;
    repeat (6) step();
    check("rep_count", 8'(acc_q.size()), 8'd4);
    for (int k = 0; k < 4; k++) check_order("rep_id", k, 2);
    repeat_en = 1'b0;
    acc_q.delete();
    btn_db = 4'b0100;
    repeat (37) step();
    btn_db = 4'b0000;
    repeat (6) step();
    check("norep_count", 8'(acc_q.size()), 8'd1);

    // Reset in the middle of a stalled handshake with overrun set.
    bus.cmd_ready = 1'b0;
    btn_db = 4'b1000;
    repeat (2) step();
    btn_db = 4'b0000;
    step();
    btn_db = 4'b1000;
    step();
    check("pre_rst_valid", {7'd0, bus.cmd_valid}, 8'd1);
    check("pre_rst_overrun", {7'd0, overrun}, 8'd1);
    reset = 1'b1;
    step();
    check("rst_valid", {7'd0, bus.cmd_valid}, 8'd0);
    check("rst_overrun", {7'd0, overrun}, 8'd0);
    reset = 1'b0;
    btn_db = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("rst_tick", {7'd0, m_tick}, (c == 4) ? 8'd1 : 8'd0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 299) begin
        btn_db = 4'b0000;
        reset  = 1'b0;
        step();
        repeat_en = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 39) == 0) btn_db[i] = ~btn_db[i];
      end
      bus.cmd_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
